// File: rtl/char_rx_fifo_if.sv
// Handshake bundle between the UART receiver, the receive FIFO and the core's character input.
// The master drives the UART byte and the core's acknowledge; the slave is the FIFO.
interface char_rx_fifo_if #(
    parameter int AW = 4
);
    logic [7:0]  UIN;
    logic        URDA;
    logic        UACK;
    logic [7:0]  COUT;
    logic        CRDA;
    logic        CACK;
    logic [AW:0] COUNT;
    logic        HIGH_WATER;

    modport master (
        output UIN, URDA, CACK,
        input  UACK, COUT, CRDA, COUNT, HIGH_WATER
    );

    modport slave (
        input  UIN, URDA, CACK,
        output UACK, COUT, CRDA, COUNT, HIGH_WATER
    );
endinterface

// File: rtl/char_rx_fifo.sv
// Receive-side byte FIFO: drains the UART's RDA/ACK holding register and presents a
// first-word-fall-through RDA/ACK stream to the core, with a registered high-water flag.
module char_rx_fifo #(
    parameter int AW        = 4,
    parameter int HW_MARGIN = 4
) (
    input logic           CLK,
    input logic           RESET,
    char_rx_fifo_if.slave bus
);
    localparam int          DEPTH     = 2 ** AW;
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] HW_THRESH = (AW + 1)'(DEPTH - HW_MARGIN);
    localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_uack;
    logic          r_high_water;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_nxt;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // UACK blocks the push for one cycle: the UART needs that cycle to drop URDA.
    assign w_push = bus.URDA && !w_full && !r_uack;
    assign w_pop  = bus.CACK && !w_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_uack       <= 1'b0;
            r_high_water <= 1'b0;
        end else begin
            r_uack       <= w_push;
            r_count      <= w_count_nxt;
            r_high_water <= (w_count_nxt >= HW_THRESH);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.UIN;
        end
    end

    assign bus.UACK       = r_uack;
    assign bus.CRDA       = !w_empty;
    assign bus.COUT       = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign bus.COUNT      = r_count;
    assign bus.HIGH_WATER = r_high_water;
endmodule

// File: tb/tb_char_rx_fifo.sv
// Directed bench for char_rx_fifo: reset, single byte, fill/drain across wrap,
// simultaneous push/pop, spurious acknowledges on empty.
module tb_char_rx_fifo;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    char_rx_fifo_if #(.AW(4)) bus ();

    char_rx_fifo #(.AW(4), .HW_MARGIN(4)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_count"}, 32'(bus.COUNT), 0);
        chk({tag, "_crda"},  32'(bus.CRDA), 0);
        chk({tag, "_cout"},  32'(bus.COUT), 0);
        chk({tag, "_uack"},  32'(bus.UACK), 0);
        chk({tag, "_hw"},    32'(bus.HIGH_WATER), 0);
    endtask

    task automatic send(input logic [7:0] b);
        logic got;
        got = 1'b0;
        bus.URDA = 1'b1;
        bus.UIN  = b;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.UACK === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("send_uack", 32'(got), 1);
        step();
        bus.URDA = 1'b0;
    endtask

    task automatic pop_pulse();
        bus.CACK = 1'b1;
        step();
        bus.CACK = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.URDA = 1'b0;
        bus.UIN  = 8'h00;
        bus.CACK = 1'b0;

        // Power-on reset
        step(); step(); step();
        chk_idle("por");
        rst_n = 1'b1;

        // Build COUNT = 5, then reset mid-run with a byte pending at the UART
        send(8'h11); send(8'h12); send(8'h13); send(8'h14); send(8'h15);
        chk("pre_rst_count", 32'(bus.COUNT), 5);
        chk("pre_rst_cout", 32'(bus.COUT), 32'h11);
        bus.URDA = 1'b1;
        bus.UIN  = 8'h41;
        rst_n = 1'b0;
        #1;
        chk_idle("rst_async");
        step(); step(); step();
        chk_idle("rst_hold");
        rst_n = 1'b1;
        chk_idle("rst_release");

        // Single byte: pending 0x41 taken on first edge after release
        step();
        chk("single_uack", 32'(bus.UACK), 1);
        chk("single_crda", 32'(bus.CRDA), 1);
        chk("single_cout", 32'(bus.COUT), 32'h41);
        chk("single_count", 32'(bus.COUNT), 1);
        step();
        chk("single_uack_drop", 32'(bus.UACK), 0);
        chk("single_no_double", 32'(bus.COUNT), 1);
        bus.URDA = 1'b0;
        step();
        chk("single_uack_low", 32'(bus.UACK), 0);
        pop_pulse();
        chk("single_pop_crda", 32'(bus.CRDA), 0);
        chk("single_pop_count", 32'(bus.COUNT), 0);
        chk("single_pop_cout", 32'(bus.COUT), 0);

        // Fill to full with 0x00..0x0F, then hold 0x10
        for (int i = 0; i < 16; i++) begin
            bus.URDA = 1'b1;
            bus.UIN  = 8'(i);
            step();
            chk("fill_uack", 32'(bus.UACK), 1);
            chk("fill_count", 32'(bus.COUNT), 32'(i + 1));
            chk("fill_hw", 32'(bus.HIGH_WATER), 32'((i + 1) >= 12));
            step();
            chk("fill_uack_gap", 32'(bus.UACK), 0);
        end
        bus.URDA = 1'b1;
        bus.UIN  = 8'h10;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_no_uack", 32'(bus.UACK), 0);
            chk("full_count", 32'(bus.COUNT), 16);
        end
        chk("full_cout", 32'(bus.COUT), 32'h00);
        chk("full_hw", 32'(bus.HIGH_WATER), 1);

        // Drain from full: pop frees a slot, held byte pushed on the next edge
        pop_pulse();
        chk("unfull_count", 32'(bus.COUNT), 15);
        chk("unfull_cout", 32'(bus.COUT), 32'h01);
        chk("unfull_uack", 32'(bus.UACK), 0);
        step();
        chk("resume_uack", 32'(bus.UACK), 1);
        chk("resume_count", 32'(bus.COUNT), 16);
        step();
        bus.URDA = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_cout", 32'(bus.COUT), 32'(i));
            pop_pulse();
            chk("drain_count", 32'(bus.COUNT), 32'(16 - i));
            chk("drain_hw", 32'(bus.HIGH_WATER), 32'((16 - i) >= 12));
        end
        chk_idle("drained");

        // Simultaneous push and pop at COUNT = 3
        send(8'hA1); send(8'hA2); send(8'hA3);
        chk("sim_pre_count", 32'(bus.COUNT), 3);
        chk("sim_pre_cout", 32'(bus.COUT), 32'hA1);
        bus.URDA = 1'b1;
        bus.UIN  = 8'hA4;
        bus.CACK = 1'b1;
        step();
        bus.CACK = 1'b0;
        chk("sim_count", 32'(bus.COUNT), 3);
        chk("sim_cout", 32'(bus.COUT), 32'hA2);
        chk("sim_uack", 32'(bus.UACK), 1);
        step();
        bus.URDA = 1'b0;
        chk("sim_tail0", 32'(bus.COUT), 32'hA2);
        pop_pulse();
        chk("sim_tail1", 32'(bus.COUT), 32'hA3);
        pop_pulse();
        chk("sim_tail2", 32'(bus.COUT), 32'hA4);
        pop_pulse();
        chk("sim_empty", 32'(bus.COUNT), 0);

        // Spurious CACK on empty
        for (int i = 0; i < 4; i++) begin
            pop_pulse();
            chk("spur_count", 32'(bus.COUNT), 0);
            chk("spur_crda", 32'(bus.CRDA), 0);
        end
        send(8'h5A);
        chk("spur_next_cout", 32'(bus.COUT), 32'h5A);
        chk("spur_next_count", 32'(bus.COUNT), 1);
        pop_pulse();
        chk("spur_next_pop", 32'(bus.COUNT), 0);

        // Simultaneous push and CACK on empty: push wins, pop ignored
        bus.URDA = 1'b1;
        bus.UIN  = 8'h77;
        bus.CACK = 1'b1;
        step();
        bus.CACK = 1'b0;
        chk("empty_sim_count", 32'(bus.COUNT), 1);
        chk("empty_sim_cout", 32'(bus.COUT), 32'h77);
        step();
        bus.URDA = 1'b0;
        pop_pulse();
        chk_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/char_rx_fifo.md
Name: char_rx_fifo

Overview:
- Receive-side byte buffer between the UART receiver and the Brainfuck core's character input port.
- Drains bytes from the UART's single-byte RDA/ACK holding register into an on-chip FIFO, so the core can fall behind bursty serial input without dropping characters.
- Presents the buffered stream to the core on the same RDA/ACK handshake, and raises a high-water flag for flow control.

Parameters:
- AW, 4, address width; FIFO depth = 2**AW entries (default 16).
- HW_MARGIN, 4, HIGH_WATER asserts when occupancy >= 2**AW - HW_MARGIN; legal range 1..2**AW.

Ports:
- CLK  in  1  system clock (CLK_MAIN domain).
- RESET  in  1  asynchronous, active-low reset.
- UIN  in  8  byte from the UART receiver, valid while URDA is high.
- URDA  in  1  UART has a received byte pending (level).
- UACK  out  1  one-cycle pulse: byte on UIN accepted; the UART clears URDA.
- COUT  out  8  head-of-FIFO byte to the core's CIN.
- CRDA  out  1  FIFO non-empty (level), to the core's CRDA.
- CACK  in  1  one-cycle pulse from the core: head byte consumed.
- COUNT  out  AW+1  current occupancy, 0..2**AW.
- HIGH_WATER  out  1  occupancy at or above the threshold (registered).

Behaviour:
- Reset (RESET low, asynchronous):
  - Read and write pointers, COUNT, UACK, CRDA and HIGH_WATER go to 0.
  - COUT reads 8'h00.
  - Storage contents are don't-care.
  - Reset mid-burst discards all buffered bytes.
  - A byte pending at the UART is taken normally after reset release.
- Push condition, evaluated each rising edge: URDA && !full && !UACK.
  - On a push, UIN is written at wr_ptr, wr_ptr increments (wraps mod 2**AW), and UACK is registered high for exactly the next cycle.
  - No push is allowed while UACK is high. This is the UART's one-cycle latency to drop URDA, and it guarantees no double capture.
  - Back-to-back UART bytes therefore sustain at most one push per 2 cycles, far above the line rate.
- Full (COUNT == 2**AW):
  - No push and no UACK. The UART keeps its byte and URDA stays high.
  - The push resumes on the first edge after a pop frees a slot.
  - No bytes are lost inside this block. Loss can only occur in the UART if its own holding register is overwritten.
- Pop condition: CACK && CRDA.
  - rd_ptr increments (wraps) and COUNT decrements.
  - CACK while empty is ignored: no pointer or count change.
- Simultaneous push and pop on the same edge:
  - Both take effect and COUNT is unchanged.
  - If full, the pop is honoured and the push waits for the next edge, because the full check uses the pre-edge count.
  - If empty, the push happens and the pop is ignored.
- Read side: first-word fall-through.
  - COUT = mem[rd_ptr] whenever CRDA = 1, and 8'h00 when empty.
  - CRDA = (COUNT != 0).
  - Latency from the push edge to CRDA high is 1 cycle; the byte appears on COUT in the same cycle.
  - After a pop, the next byte is on COUT in the following cycle.
- HIGH_WATER is a registered compare of the next-state COUNT against the threshold, so it updates on the same edge as COUNT.
- Ordering is strict FIFO. Pointer wrap at 2**AW is transparent: full and empty are distinguished by COUNT, not by pointer equality.
- Arithmetic: COUNT is AW+1 bits; pointers are AW bits. No saturating or negative states are reachable.

Test Plan:
- Reset then idle:
  - RESET low for 3 cycles, mid-run with COUNT = 5.
  - Required: COUNT = 0, CRDA = 0, COUT = 8'h00, UACK = 0, HIGH_WATER = 0 while low and after release.
- Single byte:
  - UART model presents 8'h41 with URDA high.
  - Required: UACK high exactly 1 cycle; CRDA high next cycle with COUT = 8'h41.
  - One CACK pulse: CRDA = 0, COUNT = 0.
- Fill to full (AW = 4):
  - Push bytes 8'h00..8'h10 with no CACK.
  - Required: 16 UACKs; the 17th byte (8'h10) is held with URDA high and no UACK; COUNT = 16.
  - HIGH_WATER rises on the edge where COUNT becomes 12.
- Drain from full:
  - One CACK pulse.
  - Required: next edge pushes 8'h10.
  - Draining then returns 8'h00..8'h10 in order across the pointer wrap.
- Simultaneous push and pop:
  - With COUNT = 3, CACK coincides with a push edge.
  - Required: COUNT stays 3, the head advances, and the new byte lands at the tail.
- Spurious CACK on empty:
  - 4 CACK pulses with COUNT = 0.
  - Required: pointers unchanged; the next pushed byte 8'h5A appears on COUT with COUNT = 1.
